// File: rtl/valid_ready_multi_channel_fifo.sv
// valid_ready_multi_channel_fifo: CHANNELS FIFOs in one shared memory, valid-ready, optional flush (VALID_READY_MULTI_CHANNEL_FIFO_FLUSH_EN)
module valid_ready_multi_channel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CHANNELS = 4,
  localparam int CH_LOG2 = $clog2(CHANNELS),
  localparam int DEPTH_LOG2 = $clog2(DEPTH),
  localparam int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [WIDTH-1:0]    write_data,
  input  logic [CH_LOG2-1:0]  write_channel,
  input  logic                write_valid,
  output logic                write_ready,
  input  logic [CH_LOG2-1:0]  read_channel,
  output logic [WIDTH-1:0]    read_data,
  output logic                read_valid,
  input  logic                read_ready,
`ifdef VALID_READY_MULTI_CHANNEL_FIFO_FLUSH_EN
  input  logic                flush_valid,
  input  logic [CH_LOG2-1:0]  flush_channel,
`endif
  output logic [CHANNELS-1:0] full,
  output logic [CHANNELS-1:0] empty,
  output logic [LEVEL_W-1:0]  read_level
);
  localparam int ADDR_W = $clog2(CHANNELS * DEPTH);
  logic [WIDTH-1:0] mem [CHANNELS*DEPTH];
  logic [DEPTH_LOG2-1:0] rptr [CHANNELS];
  logic [DEPTH_LOG2-1:0] wptr [CHANNELS];
  logic [LEVEL_W-1:0] count [CHANNELS];
  logic [LEVEL_W-1:0] cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] push_oh, pop_oh, flush_oh;
  logic [ADDR_W-1:0] waddr, raddr;
  logic push, pop, wr_blk, rd_blk;

  function automatic logic [DEPTH_LOG2-1:0] inc(input logic [DEPTH_LOG2-1:0] p);
    return (p == DEPTH_LOG2'(DEPTH - 1)) ? '0 : p + DEPTH_LOG2'(1);
  endfunction

`ifdef VALID_READY_MULTI_CHANNEL_FIFO_FLUSH_EN
  // a channel being flushed accepts no traffic that cycle
  assign flush_oh = flush_valid ? (CHANNELS'(1) << flush_channel) : '0;
  assign wr_blk = flush_valid && (flush_channel == write_channel);
  assign rd_blk = flush_valid && (flush_channel == read_channel);
`else
  assign flush_oh = '0;
  assign wr_blk = 1'b0;
  assign rd_blk = 1'b0;
`endif

  assign write_ready = ~full[write_channel] & ~wr_blk;
  assign read_valid = ~empty[read_channel] & ~rd_blk;
  assign read_level = count[read_channel];
  assign push = write_valid & write_ready;
  assign pop = read_valid & read_ready;
  assign push_oh = push ? (CHANNELS'(1) << write_channel) : '0;
  assign pop_oh = pop ? (CHANNELS'(1) << read_channel) : '0;
  assign waddr = ADDR_W'(write_channel) * ADDR_W'(DEPTH) + ADDR_W'(wptr[write_channel]);
  assign raddr = ADDR_W'(read_channel) * ADDR_W'(DEPTH) + ADDR_W'(rptr[read_channel]);
  assign read_data = mem[raddr];

  always_comb
    for (int i = 0; i < CHANNELS; i++)
      cnt_nxt[i] = flush_oh[i] ? '0 : count[i] + LEVEL_W'(push_oh[i]) - LEVEL_W'(pop_oh[i]);

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < CHANNELS; i++) begin
        rptr[i] <= '0;
        wptr[i] <= '0;
        count[i] <= '0;
      end
      full <= '0;
      empty <= '1;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        count[i] <= cnt_nxt[i];
        wptr[i] <= flush_oh[i] ? '0 : push_oh[i] ? inc(wptr[i]) : wptr[i];
        rptr[i] <= flush_oh[i] ? '0 : pop_oh[i] ? inc(rptr[i]) : rptr[i];
        full[i] <= cnt_nxt[i] == LEVEL_W'(DEPTH);
        empty[i] <= cnt_nxt[i] == '0;
      end
    end

  always_ff @(posedge clock)
    if (push) mem[waddr] <= write_data;
endmodule

// File: tb/tb_valid_ready_multi_channel_fifo.sv
// tb_valid_ready_multi_channel_fifo: directed-vector bench for valid_ready_multi_channel_fifo (WIDTH=8, DEPTH=4, CHANNELS=4)
module tb_valid_ready_multi_channel_fifo;
  logic clock = 0, resetn = 0;
  logic [7:0] write_data = '0, read_data;
  logic [1:0] write_channel = '0, read_channel = '0;
  logic write_valid = 0, write_ready, read_valid, read_ready = 0;
  logic [3:0] full, empty;
  logic [2:0] read_level;
  int vectors = 0, miscompares = 0;
`ifdef VALID_READY_MULTI_CHANNEL_FIFO_FLUSH_EN
  logic flush_valid = 0;
  logic [1:0] flush_channel = '0;
`endif

  valid_ready_multi_channel_fifo #(.WIDTH(8), .DEPTH(4), .CHANNELS(4)) dut (
    .clock(clock), .resetn(resetn),
    .write_data(write_data), .write_channel(write_channel), .write_valid(write_valid), .write_ready(write_ready),
    .read_channel(read_channel), .read_data(read_data), .read_valid(read_valid), .read_ready(read_ready),
`ifdef VALID_READY_MULTI_CHANNEL_FIFO_FLUSH_EN
    .flush_valid(flush_valid), .flush_channel(flush_channel),
`endif
    .full(full), .empty(empty), .read_level(read_level)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    miscompares++;
    $error("FAIL timeout: bench did not complete within 100000 time units");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step(input logic wv, input logic [1:0] wc, input logic [7:0] wd, input logic rr, input logic [1:0] rc);
    write_valid = wv;
    write_channel = wc;
    write_data = wd;
    read_ready = rr;
    read_channel = rc;
    @(posedge clock);
    #1;
    write_valid = 0;
    read_ready = 0;
  endtask

  task automatic sel(input logic [1:0] rc);
    read_channel = rc;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if (empty !== 4'hF || full !== 4'h0 || read_valid !== 1'b0 || read_level !== 3'd0 || write_ready !== 1'b1) begin
      miscompares++;
      $error("FAIL reset state: empty=%0h full=%0h read_valid=%0b read_level=%0d write_ready=%0b", empty, full, read_valid, read_level, write_ready);
    end
    chk("rst_empty", empty, 4'hF);
    chk("rst_full", full, 4'h0);
    chk("rst_rvalid", read_valid, 1'b0);
    chk("rst_level", read_level, 3'd0);
    chk("rst_wready", write_ready, 1'b1);
    resetn = 1;
    @(posedge clock);
    #1;
    step(1, 2, 8'hA1, 0, 2);
    chk("a1_empty", empty, 4'b1011);
    chk("a1_rvalid", read_valid, 1'b1);
    chk("a1_rdata", read_data, 8'hA1);
    chk("a1_level", read_level, 3'd1);
    step(0, 0, 0, 1, 2);
    chk("a1_drain", empty, 4'hF);
    for (int i = 0; i < 4; i++) begin
      write_channel = 1;
      #1;
      chk("fill_wready", write_ready, 1'b1);
      step(1, 1, 8'(8'h10 + i), 0, 1);
    end
    chk("fill_full", full, 4'b0010);
    write_channel = 1;
    #1;
    chk("full_wready1", write_ready, 1'b0);
    write_channel = 0;
    #1;
    chk("full_wready0", write_ready, 1'b1);
    step(1, 1, 8'hEE, 0, 1);
    chk("ovf_level", read_level, 3'd4);
    for (int i = 0; i < 4; i++) begin
      sel(1);
      vectors++;
      if (read_data !== 8'(8'h10 + i)) begin
        miscompares++;
        $error("FAIL ch1_order observed=%0h expected=%0h", read_data, 8'(8'h10 + i));
      end
      step(0, 0, 0, 1, 1);
    end
    chk("ch1_level0", read_level, 3'd0);
    chk("ch1_empty", empty, 4'hF);
    step(1, 0, 8'h20, 0, 0);
    step(1, 0, 8'h21, 0, 0);
    chk("pp_head", read_data, 8'h20);
    step(1, 0, 8'h22, 1, 0);
    chk("pp_level", read_level, 3'd2);
    chk("pp_data1", read_data, 8'h21);
    step(0, 0, 0, 1, 0);
    chk("pp_data2", read_data, 8'h22);
    step(0, 0, 0, 1, 0);
    chk("pp_empty", empty, 4'hF);
    for (int i = 0; i < 3; i++) step(1, 3, 8'(i), 0, 3);
    chk("w_level", read_level, 3'd3);
    for (int i = 3; i < 10; i++) begin
      sel(3);
      vectors++;
      if (read_data !== 8'(i - 3)) begin
        miscompares++;
        $error("FAIL w_data observed=%0h expected=%0h", read_data, 8'(i - 3));
      end
      step(1, 3, 8'(i), 1, 3);
    end
    chk("w_level2", read_level, 3'd3);
    chk("w_iso", empty[2:0], 3'b111);
    for (int i = 7; i < 10; i++) begin
      sel(3);
      vectors++;
      if (read_data !== 8'(i)) begin
        miscompares++;
        $error("FAIL w_tail observed=%0h expected=%0h", read_data, 8'(i));
      end
      step(0, 0, 0, 1, 3);
    end
    chk("w_empty", empty, 4'hF);
    step(1, 1, 8'h31, 0, 0);
    step(1, 1, 8'h32, 0, 0);
    step(1, 0, 8'h40, 0, 0);
    step(1, 0, 8'h41, 1, 1);
    sel(1);
    chk("x_lvl1", read_level, 3'd1);
    chk("x_dat1", read_data, 8'h32);
    sel(0);
    chk("x_lvl0", read_level, 3'd2);
    chk("x_dat0", read_data, 8'h40);
`ifdef VALID_READY_MULTI_CHANNEL_FIFO_FLUSH_EN
    for (int i = 0; i < 3; i++) step(1, 2, 8'(8'h50 + i), 0, 2);
    flush_valid = 1;
    flush_channel = 2;
    write_channel = 2;
    read_channel = 2;
    #1;
    chk("f_wready", write_ready, 1'b0);
    chk("f_rvalid", read_valid, 1'b0);
    @(posedge clock);
    #1;
    flush_valid = 0;
    chk("f_empty2", empty[2], 1'b1);
    sel(2);
    chk("f_level2", read_level, 3'd0);
    sel(0);
    chk("f_level0", read_level, 3'd2);
    sel(1);
    chk("f_level1", read_level, 3'd1);
`endif
    @(negedge clock);
    #2;
    resetn = 0;
    #1;
    chk("arst_empty", empty, 4'hF);
    chk("arst_level", read_level, 3'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
